// File: rtl/axis_strip_pkg.sv
// Shared types and byte-lane helpers for the AXI-Stream header strip stage.
package axis_strip_pkg;

  localparam int BYTE_W    = 8;
  localparam int MAX_LANES = 128;

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    STREAM,
    FLUSH
  } state_t;

  // MSB-first mask with the top cnt of lanes lanes set; callers cast to their width.
  function automatic logic [MAX_LANES-1:0] keep_from_cnt(input int cnt, input int lanes);
    logic [MAX_LANES-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (i < lanes && i >= lanes - cnt) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic int cnt_from_keep(input logic [MAX_LANES-1:0] keep);
    int c;
    c = 0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (keep[i]) c++;
    end
    return c;
  endfunction

endpackage

// File: rtl/axis_byte_realign.sv
// Joins the tail of a held beat with the head of a new beat for an S-byte strip.
module axis_byte_realign
  import axis_strip_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int CNT_W        = $clog2(DATA_BYTE_WD) + 1
) (
  input  logic [DATA_WD-1:0] residual,
  input  logic [DATA_WD-1:0] new_word,
  input  logic [CNT_W-1:0]   shift,
  output logic [DATA_WD-1:0] joined
);

  int lsh;
  int rsh;

  // A shift by the full word width yields zero, which covers S=0 and S=D.
  always_comb begin
    lsh    = BYTE_W * int'(shift);
    rsh    = BYTE_W * (DATA_BYTE_WD - int'(shift));
    joined = (residual << lsh) | (new_word >> rsh);
  end

endmodule

// File: rtl/axi_stream_strip_header.sv
// Removes S leading bytes of each AXI-Stream packet and re-packs the payload into full beats.
// Define AXIS_STRIP_HDR_CAPTURE_EN to expose the stripped header bytes on hdr_valid/hdr_data/hdr_keep.
module axi_stream_strip_header
  import axis_strip_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_strip,
  input  logic [BYTE_CNT_WD:0]    strip_cnt,
  output logic                    ready_strip,
`ifdef AXIS_STRIP_HDR_CAPTURE_EN
  output logic                    hdr_valid,
  output logic [DATA_WD-1:0]      hdr_data,
  output logic [DATA_BYTE_WD-1:0] hdr_keep,
`endif
  output logic                    drop_pkt
);

  localparam int               CNT_W = BYTE_CNT_WD + 1;
  localparam logic [CNT_W-1:0] MAX_S = CNT_W'(DATA_BYTE_WD);

  function automatic logic [DATA_BYTE_WD-1:0] keep_of(input int cnt);
    return DATA_BYTE_WD'(keep_from_cnt(cnt, DATA_BYTE_WD));
  endfunction

  function automatic logic [DATA_WD-1:0] lane_mask(input logic [DATA_BYTE_WD-1:0] keep);
    logic [DATA_WD-1:0] m;
    for (int i = 0; i < DATA_BYTE_WD; i++) m[BYTE_W*i +: BYTE_W] = {BYTE_W{keep[i]}};
    return m;
  endfunction

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        s_q;
  logic [CNT_W-1:0]        n_q;
  logic [DATA_WD-1:0]      resid_q;

  logic                    out_free, accept, cmd_acc, pass_mode;
  logic                    emit, emit_last, drop_d, load_resid, load_n;
  logic [DATA_BYTE_WD-1:0] emit_keep;
  logic [DATA_WD-1:0]      ra_resid, ra_new, joined;
  int                      s_int, n_in, r_int;

  assign out_free    = !valid_out || ready_out;
  assign ready_in    = (state_q == FIRST || state_q == STREAM) && out_free;
  assign ready_strip = (state_q == IDLE);
  assign accept      = valid_in && ready_in;
  assign cmd_acc     = valid_strip && ready_strip;
  assign pass_mode   = (s_q == '0);

  assign s_int = int'(s_q);
  assign r_int = DATA_BYTE_WD - s_int;
  assign n_in  = cnt_from_keep(MAX_LANES'(keep_in));

  // One realigner serves every state: FIRST and FLUSH shift a single word, STREAM joins two.
  assign ra_resid = (state_q == FIRST || pass_mode) ? data_in : resid_q;
  assign ra_new   = (state_q == STREAM && !pass_mode) ? data_in : '0;

  axis_byte_realign #(
    .DATA_WD     (DATA_WD),
    .DATA_BYTE_WD(DATA_BYTE_WD),
    .CNT_W       (CNT_W)
  ) u_realign (
    .residual(ra_resid),
    .new_word(ra_new),
    .shift   (s_q),
    .joined  (joined)
  );

  always_comb begin
    // NOTE: every signal driven here is given a default first so no path can infer a latch.
    state_d    = state_q;
    emit       = 1'b0;
    emit_keep  = '1;
    emit_last  = 1'b0;
    drop_d     = 1'b0;
    load_resid = 1'b0;
    load_n     = 1'b0;
    case (state_q)
      IDLE: if (cmd_acc) state_d = FIRST;
      FIRST: if (accept) begin
        if (!last_in) begin
          state_d    = STREAM;
          load_resid = 1'b1;
          emit       = pass_mode;
        end else begin
          state_d = IDLE;
          if (n_in > s_int) begin
            emit      = 1'b1;
            emit_keep = keep_of(n_in - s_int);
            emit_last = 1'b1;
          end else begin
            drop_d = 1'b1;
          end
        end
      end
      STREAM: if (accept) begin
        emit = 1'b1;
        if (pass_mode) begin
          emit_keep = keep_in;
          emit_last = last_in;
          if (last_in) state_d = IDLE;
        end else if (!last_in) begin
          load_resid = 1'b1;
        end else if (r_int + n_in <= DATA_BYTE_WD) begin
          emit_keep = keep_of(r_int + n_in);
          emit_last = 1'b1;
          state_d   = IDLE;
        end else begin
          // Tail spills past one beat: send a full beat now, the rest from FLUSH.
          load_resid = 1'b1;
          load_n     = 1'b1;
          state_d    = FLUSH;
        end
      end
      FLUSH: if (out_free) begin
        emit      = 1'b1;
        emit_keep = keep_of(int'(n_q) - s_int);
        emit_last = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q  <= IDLE;
      s_q      <= '0;
      n_q      <= '0;
      drop_pkt <= 1'b0;
    end else begin
      state_q  <= state_d;
      drop_pkt <= drop_d;
      if (cmd_acc) s_q <= (strip_cnt > MAX_S) ? MAX_S : strip_cnt;
      if (load_n)  n_q <= CNT_W'(n_in);
    end
  end

  // NOTE: the residual word is deliberately not reset; it is always written before it is read.
  always_ff @(posedge clk) begin
    if (load_resid) resid_q <= data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      keep_out  <= '0;
      last_out  <= 1'b0;
    end else if (out_free) begin
      valid_out <= emit;
      if (emit) begin
        data_out <= joined & lane_mask(emit_keep);
        keep_out <= emit_keep;
        last_out <= emit_last;
      end
    end
  end

`ifdef AXIS_STRIP_HDR_CAPTURE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_valid <= 1'b0;
      hdr_data  <= '0;
      hdr_keep  <= '0;
    end else begin
      hdr_valid <= accept && (state_q == FIRST) && !pass_mode;
      if (accept && state_q == FIRST && !pass_mode) begin
        hdr_data <= data_in & lane_mask(keep_of(s_int));
        hdr_keep <= keep_of(s_int);
      end
    end
  end
`endif

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Directed table-driven bench for axi_stream_strip_header with DATA_WD=32.
module tb_axi_stream_strip_header;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] data_in;
  logic [3:0]  keep_in;
  logic        last_in;
  logic        ready_in;
  logic        valid_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;
  logic        ready_out;
  logic        valid_strip;
  logic [2:0]  strip_cnt;
  logic        ready_strip;
  logic        drop_pkt;
`ifdef AXIS_STRIP_HDR_CAPTURE_EN
  logic        hdr_valid;
  logic [31:0] hdr_data;
  logic [3:0]  hdr_keep;
`endif

  always #5 clk = ~clk;

  axi_stream_strip_header #(.DATA_WD(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .data_in    (data_in),
    .keep_in    (keep_in),
    .last_in    (last_in),
    .ready_in   (ready_in),
    .valid_out  (valid_out),
    .data_out   (data_out),
    .keep_out   (keep_out),
    .last_out   (last_out),
    .ready_out  (ready_out),
    .valid_strip(valid_strip),
    .strip_cnt  (strip_cnt),
    .ready_strip(ready_strip),
`ifdef AXIS_STRIP_HDR_CAPTURE_EN
    .hdr_valid  (hdr_valid),
    .hdr_data   (hdr_data),
    .hdr_keep   (hdr_keep),
`endif
    .drop_pkt   (drop_pkt)
  );

  typedef struct {
    logic        rst;
    logic        vs;
    logic [2:0]  sc;
    logic        vi;
    logic [31:0] di;
    logic [3:0]  ki;
    logic        li;
    logic        ro;
    logic        evo;
    logic [31:0] edo;
    logic [3:0]  eko;
    logic        elo;
    logic        eri;
    logic        ers;
    logic        edp;
  } vec_t;

  vec_t        vecs[$];
  int          checks   = 0;
  int          failures = 0;

  logic [31:0] pd[4];
  logic [3:0]  pk[4];
  int          in_idx, out_idx;
  logic        held, acc;
  logic [31:0] hd;
  logic [3:0]  hk;
  logic        hl;

  function automatic vec_t mk(input logic r, input logic vs, input logic [2:0] sc, input logic vi,
                              input logic [31:0] di, input logic [3:0] ki, input logic li,
                              input logic ro, input logic evo, input logic [31:0] edo,
                              input logic [3:0] eko, input logic elo, input logic eri,
                              input logic ers, input logic edp);
    vec_t v;
    v.rst = r;   v.vs = vs;   v.sc = sc;   v.vi = vi;   v.di = di;   v.ki = ki;
    v.li = li;   v.ro = ro;   v.evo = evo; v.edo = edo; v.eko = eko; v.elo = elo;
    v.eri = eri; v.ers = ers; v.edp = edp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before the end of the test");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
    ready_out = 1'b1; valid_strip = 1'b0; strip_cnt = '0;

    //          rst vs sc vi data          keep  li ro | vo data          keep  lo ri rs dp
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        4'h0, 0, 1,  0, 32'h0,        4'h0, 0, 0, 1, 0));
    // S=1, three-beat packet with a FLUSH tail
    vecs.push_back(mk(0, 1, 1, 0, 32'h0,        4'h0, 0, 1,  0, 32'h0,        4'h0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'hAABBCCDD, 4'hF, 0, 1,  0, 32'h0,        4'h0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h11223344, 4'hF, 0, 1,  1, 32'hBBCCDD11, 4'hF, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h55660000, 4'hC, 1, 1,  1, 32'h22334455, 4'hF, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        4'h0, 0, 1,  1, 32'h66000000, 4'h8, 1, 0, 1, 0));
    // S=3, two beats joined into one
    vecs.push_back(mk(0, 1, 3, 0, 32'h0,        4'h0, 0, 1,  0, 32'h0,        4'h0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h01020304, 4'hF, 0, 1,  0, 32'h0,        4'h0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'hA5000000, 4'h8, 1, 1,  1, 32'h04A50000, 4'hC, 1, 0, 1, 0));
    // new command accepted while the last beat is stalled, then S=4 drops a single-beat packet
    vecs.push_back(mk(0, 1, 4, 0, 32'h0,        4'h0, 0, 0,  1, 32'h04A50000, 4'hC, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'hCAFEF00D, 4'hF, 1, 1,  0, 32'h0,        4'h0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        4'h0, 0, 1,  0, 32'h0,        4'h0, 0, 0, 1, 0));
    // strip_cnt=7 clamps to 4
    vecs.push_back(mk(0, 1, 7, 0, 32'h0,        4'h0, 0, 1,  0, 32'h0,        4'h0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h12345678, 4'hF, 0, 1,  0, 32'h0,        4'h0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h9ABCDEF0, 4'hE, 1, 1,  1, 32'h9ABCDE00, 4'hE, 1, 0, 1, 0));
    // reset after beat 1 of an S=1 packet
    vecs.push_back(mk(0, 1, 1, 0, 32'h0,        4'h0, 0, 1,  0, 32'h0,        4'h0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'hDEADBEEF, 4'hF, 0, 1,  0, 32'h0,        4'h0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h01234567, 4'hF, 0, 1,  1, 32'hADBEEF01, 4'hF, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,        4'h0, 0, 1,  0, 32'h0,        4'h0, 0, 0, 1, 0));
    // S=2 after reset, FLUSH held by backpressure for one cycle
    vecs.push_back(mk(0, 1, 2, 0, 32'h0,        4'h0, 0, 1,  0, 32'h0,        4'h0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h10203040, 4'hF, 0, 1,  0, 32'h0,        4'h0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h50607080, 4'hF, 1, 1,  1, 32'h30405060, 4'hF, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        4'h0, 0, 0,  1, 32'h30405060, 4'hF, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        4'h0, 0, 1,  1, 32'h70800000, 4'hC, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        4'h0, 0, 1,  0, 32'h0,        4'h0, 0, 0, 1, 0));
    // S=2 single beat with n=3 > S
    vecs.push_back(mk(0, 1, 2, 0, 32'h0,        4'h0, 0, 1,  0, 32'h0,        4'h0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'hAABBCC00, 4'hE, 1, 1,  1, 32'hCC000000, 4'h8, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        4'h0, 0, 1,  0, 32'h0,        4'h0, 0, 0, 1, 0));
    // S=1 with R+n exactly one beat
    vecs.push_back(mk(0, 1, 1, 0, 32'h0,        4'h0, 0, 1,  0, 32'h0,        4'h0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h01020304, 4'hF, 0, 1,  0, 32'h0,        4'h0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h05000000, 4'h8, 1, 1,  1, 32'h02030405, 4'hF, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        4'h0, 0, 1,  0, 32'h0,        4'h0, 0, 0, 1, 0));

    @(posedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; valid_strip = vecs[i].vs; strip_cnt = vecs[i].sc;
      valid_in = vecs[i].vi; data_in = vecs[i].di; keep_in = vecs[i].ki;
      last_in = vecs[i].li; ready_out = vecs[i].ro;
      @(posedge clk);
      #1;
      check($sformatf("row%0d valid_out", i), 32'(valid_out), 32'(vecs[i].evo));
      check($sformatf("row%0d ready_in", i), 32'(ready_in), 32'(vecs[i].eri));
      check($sformatf("row%0d ready_strip", i), 32'(ready_strip), 32'(vecs[i].ers));
      check($sformatf("row%0d drop_pkt", i), 32'(drop_pkt), 32'(vecs[i].edp));
      if (vecs[i].evo || vecs[i].rst) begin
        check($sformatf("row%0d data_out", i), data_out, vecs[i].edo);
        check($sformatf("row%0d keep_out", i), 32'(keep_out), 32'(vecs[i].eko));
        check($sformatf("row%0d last_out", i), 32'(last_out), 32'(vecs[i].elo));
      end
    end

    // S=0 pass-through with ready_out toggling 1,0,1,0
    pd[0] = 32'h11111111; pk[0] = 4'hF;
    pd[1] = 32'h22222222; pk[1] = 4'hF;
    pd[2] = 32'h33333333; pk[2] = 4'hF;
    pd[3] = 32'h44440000; pk[3] = 4'hC;
    @(negedge clk);
    rst = 1'b0; valid_strip = 1'b1; strip_cnt = 3'd0; valid_in = 1'b0; ready_out = 1'b1;
    @(posedge clk);
    #1;
    check("s0 command taken", 32'(ready_strip), 32'(0));
    in_idx = 0; out_idx = 0; held = 1'b0;
    for (int cyc = 0; cyc < 40 && out_idx < 4; cyc++) begin
      @(negedge clk);
      valid_strip = 1'b0;
      ready_out   = (cyc % 2 == 0);
      if (in_idx < 4) begin
        valid_in = 1'b1; data_in = pd[in_idx]; keep_in = pk[in_idx]; last_in = (in_idx == 3);
      end else begin
        valid_in = 1'b0; last_in = 1'b0;
      end
      #1;
      if (held) begin
        check($sformatf("s0 stall hold data c%0d", cyc), data_out, hd);
        check($sformatf("s0 stall hold keep c%0d", cyc), 32'(keep_out), 32'(hk));
        check($sformatf("s0 stall hold last c%0d", cyc), 32'(last_out), 32'(hl));
      end
      held = valid_out && !ready_out;
      hd = data_out; hk = keep_out; hl = last_out;
      if (valid_out && ready_out) begin
        check($sformatf("s0 beat%0d data", out_idx), data_out, pd[out_idx]);
        check($sformatf("s0 beat%0d keep", out_idx), 32'(keep_out), 32'(pk[out_idx]));
        check($sformatf("s0 beat%0d last", out_idx), 32'(last_out), 32'(out_idx == 3));
        out_idx++;
      end
      acc = valid_in && ready_in;
      @(posedge clk);
      if (acc) in_idx++;
    end
    check("s0 beats delivered", 32'(out_idx), 32'(4));
    check("s0 beats accepted", 32'(in_idx), 32'(4));

`ifdef AXIS_STRIP_HDR_CAPTURE_EN
    @(negedge clk);
    valid_in = 1'b0; last_in = 1'b0; ready_out = 1'b1; valid_strip = 1'b1; strip_cnt = 3'd2;
    @(posedge clk);
    @(negedge clk);
    valid_strip = 1'b0; valid_in = 1'b1; data_in = 32'hDEADBEEF; keep_in = 4'hF; last_in = 1'b1;
    @(posedge clk);
    #1;
    check("hdr_valid pulse", 32'(hdr_valid), 32'(1));
    check("hdr_data", hdr_data, 32'hDEAD0000);
    check("hdr_keep", 32'(hdr_keep), 32'(4'hC));
    @(negedge clk);
    valid_in = 1'b0; last_in = 1'b0;
    @(posedge clk);
    #1;
    check("hdr_valid single pulse", 32'(hdr_valid), 32'(0));
`endif

    @(negedge clk);
    valid_in = 1'b0; valid_strip = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
